// File: rtl/clock_divider_bank.sv
// Bank of runtime-programmable integer clock dividers clocked by clk_32f.
// Each lane has a shadow divisor. A new divisor is adopted only when the
// lane's counter wraps, so the lane never produces a runt pulse. A sync
// request zeroes every lane counter together and applies all shadows
// immediately, which brings the lanes back into phase.

module clock_divider_lane #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(2)
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             div_load,
  input  logic             sync_req,
  input  logic [CNT_W-1:0] div_new,
  output logic             clk_out,
  output logic             pending,
  output logic             wrapped,
  output logic             apply
);
  logic [CNT_W-1:0] cnt, div_act, div_shd, d_eff;
  logic             wrap;

  // Divisors 0 and 1 run as 2, so the counter always has at least two states.
  always_comb d_eff = (div_act < CNT_W'(2)) ? CNT_W'(2) : div_act;

  assign wrap  = enable && (cnt == d_eff - CNT_W'(1));
  // A sync that arrives on the same edge as the wrap takes over the apply.
  assign apply = wrap && pending && !sync_req;

  // Counter, divisor adoption, and registered output compare.
  // Invariant: when pending is 0, div_shd equals div_act. A sync can
  // therefore copy the shadow into the active divisor unconditionally.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      cnt     <= '0;
      div_act <= DIV_RST;
      div_shd <= DIV_RST;
      pending <= 1'b0;
      wrapped <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (div_load) div_shd <= div_new;
      if (sync_req) begin
        cnt     <= '0;
        div_act <= div_load ? div_new : div_shd;
        pending <= 1'b0;
        wrapped <= 1'b0;
        clk_out <= 1'b0;
      end else if (enable) begin
        cnt     <= wrap ? '0 : cnt + CNT_W'(1);
        clk_out <= (cnt < (d_eff >> 1));
        if (wrap) begin
          if (pending) begin
            div_act <= div_shd;
            wrapped <= 1'b0;
          end else begin
            wrapped <= 1'b1;
          end
        end
        // A load on the wrap edge re-arms the lane for the following wrap.
        pending <= div_load | (pending & ~wrap);
      end else begin
        clk_out <= 1'b0;
        pending <= pending | div_load;
      end
    end
  end
endmodule

module clock_divider_bank #(
  parameter int                       NUM_OUT     = 3,
  parameter int                       CNT_W       = 8,
  parameter logic [NUM_OUT*CNT_W-1:0] DIV_DEFAULT = {8'd8, 8'd16, 8'd32}
) (
  input  logic                     clk_32f,
  input  logic                     reset_L,
  input  logic                     enable,
  input  logic [NUM_OUT*CNT_W-1:0] div_in,
  input  logic                     div_load,
  input  logic                     sync_req,
  output logic [NUM_OUT-1:0]       clk_out,
  output logic                     busy,
  output logic                     locked
);
  logic [NUM_OUT-1:0] pending, wrapped, apply;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    clock_divider_lane #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_DEFAULT[i*CNT_W +: CNT_W])
    ) u_lane (
      .clk_32f (clk_32f),
      .reset_L (reset_L),
      .enable  (enable),
      .div_load(div_load),
      .sync_req(sync_req),
      .div_new (div_in[i*CNT_W +: CNT_W]),
      .clk_out (clk_out[i]),
      .pending (pending[i]),
      .wrapped (wrapped[i]),
      .apply   (apply[i])
    );
  end

  assign busy = |pending;

  // Lock is asserted once every lane has completed a full period on its
  // current divisor. Any load, sync or apply drops it at once.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L)                             locked <= 1'b0;
    else if (sync_req || div_load || |apply)  locked <= 1'b0;
    else                                      locked <= (&wrapped) & ~busy;
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank. Expected clk_out vectors come from a
// closed-form phase formula (period base and divisor for each channel). They
// are queued when each edge is driven and compared after the edge.
module tb_clock_divider_bank;
  localparam int N    = 3;
  localparam int W    = 8;
  localparam int HUGE = 1 << 30;

  logic           clk_32f = 1'b0;
  logic           reset_L;
  logic           enable;
  logic [N*W-1:0] div_in;
  logic           div_load;
  logic           sync_req;
  logic [N-1:0]   clk_out;
  logic           busy;
  logic           locked;

  clock_divider_bank dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .enable  (enable),
    .div_in  (div_in),
    .div_load(div_load),
    .sync_req(sync_req),
    .clk_out (clk_out),
    .busy    (busy),
    .locked  (locked)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct { int t; logic [N-1:0] v; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int t;                       // count of enabled, out-of-reset edges
  int sync_t;
  int base[N], dv[N], sw_t[N], sw_d[N];

  function automatic bit exp_bit(int i, int tt);
    int b, d;
    if (tt == sync_t) return 1'b0;
    b = base[i]; d = dv[i];
    if (tt > sw_t[i]) begin b = sw_t[i]; d = sw_d[i]; end
    return ((tt - b - 1) % d) < (d / 2);
  endfunction

  task automatic init_model();
    t = 0; sync_t = -1;
    base = '{0, 0, 0}; dv = '{32, 16, 8};
    sw_t = '{HUGE, HUGE, HUGE}; sw_d = '{2, 2, 2};
  endtask

  task automatic sched(int i, int at, int d);
    sw_t[i] = at;
    sw_d[i] = (d < 2) ? 2 : d;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  // One clock: push the expected vector for this edge, then compare it after the edge.
  task automatic cyc();
    exp_t e, g;
    e.v = '0;
    if (enable && reset_L) begin
      t++;
      for (int i = 0; i < N; i++) e.v[i] = exp_bit(i, t);
    end
    e.t = t;
    exp_q.push_back(e);
    @(posedge clk_32f); #1;
    g = exp_q.pop_front();
    total++;
    assert (clk_out === g.v) else begin
      bad++;
      $error("FAIL clk_out t=%0d got=%b exp=%b", g.t, clk_out, g.v);
    end
    if (enable && reset_L)
      for (int i = 0; i < N; i++)
        if (t >= sw_t[i]) begin
          base[i] = sw_t[i]; dv[i] = sw_d[i]; sw_t[i] = HUGE;
        end
  endtask

  initial begin
    reset_L = 1'b0; enable = 1'b0; div_in = '0; div_load = 1'b0; sync_req = 1'b0;
    init_model();
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);

    // Defaults: periods 32/16/8, all rising on the first edge after release.
    reset_L = 1'b1; enable = 1'b1;
    repeat (32) cyc();
    chk("lock_pre", locked, 0);
    cyc();
    chk("lock_def", locked, 1);
    repeat (7) cyc();                       // t = 40

    // Mid-period load: ch2 -> 4 and ch1 -> 6 at t=48, ch0 -> 10 at t=64.
    div_in = {8'd4, 8'd6, 8'd10}; div_load = 1'b1;
    sched(2, 48, 4); sched(1, 48, 6); sched(0, 64, 10);
    cyc(); div_load = 1'b0;                 // t = 41
    chk("load_busy", busy, 1);
    chk("load_unlock", locked, 0);
    repeat (22) cyc();
    chk("busy_63", busy, 1);
    cyc();
    chk("busy_64", busy, 0);
    repeat (10) cyc();
    chk("lock_74", locked, 0);
    cyc();
    chk("lock_75", locked, 1);
    repeat (5) cyc();                       // t = 80

    // Load together with sync: ch0 = 5, ch1 = 1, ch2 = 0 (the last two run as 2).
    div_in = {8'd0, 8'd1, 8'd5}; div_load = 1'b1; sync_req = 1'b1;
    sync_t = 81;
    sched(0, 81, 5); sched(1, 81, 1); sched(2, 81, 0);
    cyc(); div_load = 1'b0; sync_req = 1'b0;
    chk("sync_busy", busy, 0);
    chk("sync_unlock", locked, 0);
    repeat (5) cyc();
    chk("lock_86", locked, 0);
    cyc();
    chk("lock_87", locked, 1);
    repeat (13) cyc();                      // t = 100

    // Seven-cycle enable gap: outputs low, counts and lock held.
    enable = 1'b0;
    repeat (7) cyc();
    chk("gap_locked", locked, 1);
    chk("gap_busy", busy, 0);
    enable = 1'b1;
    repeat (8) cyc();                       // t = 108

    // Load, then sync one edge later while the lanes are out of phase.
    div_in = {8'd3, 8'd7, 8'd12}; div_load = 1'b1;
    cyc(); div_load = 1'b0;                 // t = 109
    chk("load2_busy", busy, 1);
    sync_req = 1'b1; sync_t = 110;
    sched(0, 110, 12); sched(1, 110, 7); sched(2, 110, 3);
    cyc(); sync_req = 1'b0;                 // t = 110
    chk("sync2_busy", busy, 0);
    chk("sync2_unlock", locked, 0);
    repeat (12) cyc();
    chk("lock_122", locked, 0);
    cyc();
    chk("lock_123", locked, 1);
    repeat (7) cyc();

    // Asynchronous reset in the middle of a reconfiguration.
    div_in = {8'd2, 8'd2, 8'd2}; div_load = 1'b1;
    cyc(); div_load = 1'b0;
    chk("load3_busy", busy, 1);
    #3 reset_L = 1'b0;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_locked", locked, 0);
    repeat (2) cyc();
    reset_L = 1'b1;
    init_model();
    repeat (32) cyc();
    chk("post_busy", busy, 0);
    chk("post_lock_pre", locked, 0);
    cyc();
    chk("post_lock", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
